// File: rtl/serpent_pkg.sv
// Shared constants, S-box tables and types for the Serpent key schedule.
// Tables are the standard Serpent S0..S7, indexed by the 4-bit input nibble.
package serpent_pkg;

    localparam logic [31:0] PHI = 32'h9E3779B9;
    localparam int unsigned NUM_KEYS = 33;
    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] KEY_LEN_128 = 2'd0;
    localparam logic [1:0] KEY_LEN_192 = 2'd1;
    localparam logic [1:0] KEY_LEN_256 = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'd3, 4'd8, 4'd15, 4'd1, 4'd10, 4'd6, 4'd5, 4'd11,
          4'd14, 4'd13, 4'd4, 4'd2, 4'd7, 4'd0, 4'd9, 4'd12},
        '{4'd15, 4'd12, 4'd2, 4'd7, 4'd9, 4'd0, 4'd5, 4'd10,
          4'd1, 4'd11, 4'd14, 4'd8, 4'd6, 4'd13, 4'd3, 4'd4},
        '{4'd8, 4'd6, 4'd7, 4'd9, 4'd3, 4'd12, 4'd10, 4'd15,
          4'd13, 4'd1, 4'd14, 4'd4, 4'd0, 4'd11, 4'd5, 4'd2},
        '{4'd0, 4'd15, 4'd11, 4'd8, 4'd12, 4'd9, 4'd6, 4'd3,
          4'd13, 4'd1, 4'd2, 4'd4, 4'd10, 4'd7, 4'd5, 4'd14},
        '{4'd1, 4'd15, 4'd8, 4'd3, 4'd12, 4'd0, 4'd11, 4'd6,
          4'd2, 4'd5, 4'd4, 4'd10, 4'd9, 4'd14, 4'd7, 4'd13},
        '{4'd15, 4'd5, 4'd2, 4'd11, 4'd4, 4'd10, 4'd9, 4'd12,
          4'd0, 4'd3, 4'd14, 4'd8, 4'd13, 4'd6, 4'd7, 4'd1},
        '{4'd7, 4'd2, 4'd12, 4'd5, 4'd8, 4'd4, 4'd6, 4'd11,
          4'd14, 4'd9, 4'd1, 4'd15, 4'd13, 4'd3, 4'd10, 4'd0},
        '{4'd1, 4'd13, 4'd15, 4'd0, 4'd14, 4'd8, 4'd2, 4'd11,
          4'd7, 4'd4, 4'd12, 4'd10, 4'd9, 4'd3, 4'd5, 4'd6}
    };

    // One prekey step: ROL11 of the XOR of the four taps, PHI and the index.
    function automatic logic [31:0] prekey(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d,
                                           input logic [31:0] j);
        logic [31:0] t;
        t = a ^ b ^ c ^ d ^ PHI ^ j;
        return {t[20:0], t[31:21]};
    endfunction

endpackage

// File: rtl/serpent_sbox_slice.sv
// Bitslice S-box: applies the selected 4-bit box independently to all 32 bit columns.
module serpent_sbox_slice
    import serpent_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    output logic [31:0] y0,
    output logic [31:0] y1,
    output logic [31:0] y2,
    output logic [31:0] y3
);

    logic [3:0] nib;
    logic [3:0] sub;

    always_comb begin
        y0  = '0;
        y1  = '0;
        y2  = '0;
        y3  = '0;
        nib = '0;
        sub = '0;
        for (int b = 0; b < WORD_W; b++) begin
            nib   = {x3[b], x2[b], x1[b], x0[b]};
            sub   = SBOX[sel][nib];
            y0[b] = sub[0];
            y1[b] = sub[1];
            y2[b] = sub[2];
            y3[b] = sub[3];
        end
    end

endmodule

// File: rtl/serpent_key_schedule.sv
// Sequential Serpent key schedule: one bitslice round key per clock into a 33-entry register file.
module serpent_key_schedule
    import serpent_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] user_key,
    output logic         busy,
    output logic         keys_valid,
    output logic [127:0] k0,
    output logic [127:0] k1,
    output logic [127:0] k2,
    output logic [127:0] k3,
    output logic [127:0] k4,
    output logic [127:0] k5,
    output logic [127:0] k6,
    output logic [127:0] k7,
    output logic [127:0] k8,
    output logic [127:0] k9,
    output logic [127:0] k10,
    output logic [127:0] k11,
    output logic [127:0] k12,
    output logic [127:0] k13,
    output logic [127:0] k14,
    output logic [127:0] k15,
    output logic [127:0] k16,
    output logic [127:0] k17,
    output logic [127:0] k18,
    output logic [127:0] k19,
    output logic [127:0] k20,
    output logic [127:0] k21,
    output logic [127:0] k22,
    output logic [127:0] k23,
    output logic [127:0] k24,
    output logic [127:0] k25,
    output logic [127:0] k26,
    output logic [127:0] k27,
    output logic [127:0] k28,
    output logic [127:0] k29,
    output logic [127:0] k30,
    output logic [127:0] k31,
    output logic [127:0] k32
);

    localparam logic [5:0] LAST_R = 6'(NUM_KEYS - 1);

    state_e       state_q, state_d;
    logic [5:0]   r_q, r_d;
    logic [31:0]  win_q [8];
    logic [31:0]  win_d [8];
    logic [127:0] keys_q [NUM_KEYS];
    logic         key_we;
    logic [255:0] padded;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  y0, y1, y2, y3;
    logic [2:0]   box_sel;

    always_comb begin
        case (key_len)
            KEY_LEN_128: padded = {127'd0, 1'b1, user_key[127:0]};
            KEY_LEN_192: padded = {63'd0, 1'b1, user_key[191:0]};
            default:     padded = user_key;
        endcase
    end

    // Window holds w[4r-8..4r-1]; p0..p3 are w[4r..4r+3], chained within the cycle.
    assign p0 = prekey(win_q[0], win_q[3], win_q[5], win_q[7], {24'd0, r_q, 2'd0});
    assign p1 = prekey(win_q[1], win_q[4], win_q[6], p0, {24'd0, r_q, 2'd1});
    assign p2 = prekey(win_q[2], win_q[5], win_q[7], p1, {24'd0, r_q, 2'd2});
    assign p3 = prekey(win_q[3], win_q[6], p0, p2, {24'd0, r_q, 2'd3});

    assign box_sel = 3'd3 - r_q[2:0];

    serpent_sbox_slice u_sbox (
        .sel (box_sel),
        .x0  (p0),
        .x1  (p1),
        .x2  (p2),
        .x3  (p3),
        .y0  (y0),
        .y1  (y1),
        .y2  (y2),
        .y3  (y3)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        win_d   = win_q;
        key_we  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    r_d     = '0;
                    for (int i = 0; i < 8; i++) begin
                        win_d[i] = padded[32*i +: 32];
                    end
                end
            end
            RUN: begin
                key_we = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    win_d[i] = win_q[i+4];
                end
                win_d[4] = p0;
                win_d[5] = p1;
                win_d[6] = p2;
                win_d[7] = p3;
                if (r_q == LAST_R) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                win_q[i] <= '0;
            end
            for (int i = 0; i < NUM_KEYS; i++) begin
                keys_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            win_q   <= win_d;
            if (key_we) begin
                keys_q[r_q] <= {y3, y2, y1, y0};
            end
        end
    end

    assign busy       = (state_q == RUN);
    assign keys_valid = (state_q == DONE);

    assign k0  = keys_q[0];
    assign k1  = keys_q[1];
    assign k2  = keys_q[2];
    assign k3  = keys_q[3];
    assign k4  = keys_q[4];
    assign k5  = keys_q[5];
    assign k6  = keys_q[6];
    assign k7  = keys_q[7];
    assign k8  = keys_q[8];
    assign k9  = keys_q[9];
    assign k10 = keys_q[10];
    assign k11 = keys_q[11];
    assign k12 = keys_q[12];
    assign k13 = keys_q[13];
    assign k14 = keys_q[14];
    assign k15 = keys_q[15];
    assign k16 = keys_q[16];
    assign k17 = keys_q[17];
    assign k18 = keys_q[18];
    assign k19 = keys_q[19];
    assign k20 = keys_q[20];
    assign k21 = keys_q[21];
    assign k22 = keys_q[22];
    assign k23 = keys_q[23];
    assign k24 = keys_q[24];
    assign k25 = keys_q[25];
    assign k26 = keys_q[26];
    assign k27 = keys_q[27];
    assign k28 = keys_q[28];
    assign k29 = keys_q[29];
    assign k30 = keys_q[30];
    assign k31 = keys_q[31];
    assign k32 = keys_q[32];

endmodule

// File: tb/tb_serpent_key_schedule.sv
// Bench for serpent_key_schedule: random keys checked against a whole-schedule reference model.
module tb_serpent_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] user_key = '0;
    logic         busy;
    logic         keys_valid;
    logic [127:0] kv [33];
    logic [127:0] exp_k [33];
    int           total = 0;
    int           bad = 0;

    logic [3:0] sb [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    always #5 clk = ~clk;

    serpent_key_schedule dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .user_key(user_key),
        .busy(busy), .keys_valid(keys_valid),
        .k0(kv[0]), .k1(kv[1]), .k2(kv[2]), .k3(kv[3]), .k4(kv[4]), .k5(kv[5]),
        .k6(kv[6]), .k7(kv[7]), .k8(kv[8]), .k9(kv[9]), .k10(kv[10]), .k11(kv[11]),
        .k12(kv[12]), .k13(kv[13]), .k14(kv[14]), .k15(kv[15]), .k16(kv[16]),
        .k17(kv[17]), .k18(kv[18]), .k19(kv[19]), .k20(kv[20]), .k21(kv[21]),
        .k22(kv[22]), .k23(kv[23]), .k24(kv[24]), .k25(kv[25]), .k26(kv[26]),
        .k27(kv[27]), .k28(kv[28]), .k29(kv[29]), .k30(kv[30]), .k31(kv[31]),
        .k32(kv[32])
    );

    // Reference: full 256-bit padded key in, all 33 round keys out.
    task automatic model_keys(input logic [255:0] key);
        logic [31:0] w [140];
        logic [31:0] t;
        logic [3:0]  nib;
        logic [3:0]  o;
        int          box;
        for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
        for (int j = 0; j < 132; j++) begin
            t = w[j] ^ w[j+3] ^ w[j+5] ^ w[j+7] ^ 32'h9E3779B9 ^ 32'(j);
            w[j+8] = (t << 11) | (t >> 21);
        end
        for (int r = 0; r < 33; r++) begin
            box = (35 - r) % 8;
            for (int b = 0; b < 32; b++) begin
                nib = {w[4*r+11][b], w[4*r+10][b], w[4*r+9][b], w[4*r+8][b]};
                o = sb[box][nib];
                exp_k[r][b]      = o[0];
                exp_k[r][32+b]   = o[1];
                exp_k[r][64+b]   = o[2];
                exp_k[r][96+b]   = o[3];
            end
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic do_start(input logic [255:0] key, input logic [1:0] len);
        @(negedge clk);
        user_key = key;
        key_len  = len;
        start    = 1'b1;
    endtask

    // Counts edges from the load edge until keys_valid; scrambles inputs after load.
    task automatic wait_valid(output int n, output logic dropped);
        n = 0;
        dropped = 1'b0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            start = 1'b0;
            if (n == 1) begin
                dropped  = !keys_valid;
                user_key = rand_key();
                key_len  = 2'($urandom);
            end
            if (keys_valid) break;
        end
        if (!keys_valid) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || keys_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%b valid=%b want 0 0", busy, keys_valid);
        end
        for (int i = 0; i < 33; i++) begin
            total++;
            if (kv[i] !== 128'd0) begin
                bad++;
                $display("FAIL reset_k%0d got %h want 0", i, kv[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero256();
        int n;
        model_keys('0);
        do_start('0, 2'd2);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            start = 1'b0;
            if (n == 2) begin
                total++;
                if (dut.win_q[4] !== 32'hBBCDCCF1) begin
                    bad++;
                    $display("FAIL zero256_w0 got %h want bbcdccf1", dut.win_q[4]);
                end
            end
            if (keys_valid) break;
        end
        total++;
        if (n !== 34 || !keys_valid) begin
            bad++;
            $display("FAIL zero256_latency got %0d want 34", n);
        end
        for (int i = 0; i < 33; i++) begin
            total++;
            if (kv[i] !== exp_k[i]) begin
                bad++;
                $display("FAIL zero256_k%0d got %h want %h", i, kv[i], exp_k[i]);
            end
        end
    endtask

    task automatic test_padding();
        logic [255:0] k, eq;
        logic [1:0]   len;
        int           n;
        logic         dropped;
        for (int t = 0; t < 4; t++) begin
            len = 2'(t);
            k   = rand_key();
            if (t == 0) eq = {127'd0, 1'b1, k[127:0]};
            else if (t == 1) eq = {63'd0, 1'b1, k[191:0]};
            else eq = k;
            model_keys(eq);
            do_start(k, len);
            wait_valid(n, dropped);
            total++;
            if (n !== 34 || dropped !== 1'b1) begin
                bad++;
                $display("FAIL pad_len%0d_timing edges=%0d dropped=%b want 34 1", t, n, dropped);
            end
            for (int i = 0; i < 33; i++) begin
                total++;
                if (kv[i] !== exp_k[i]) begin
                    bad++;
                    $display("FAIL pad_len%0d_k%0d got %h want %h", t, i, kv[i], exp_k[i]);
                end
            end
        end
    endtask

    task automatic test_masking();
        logic [255:0] k;
        int           n;
        logic         dropped;
        k = rand_key();
        k[255:128] = '1;
        model_keys({127'd0, 1'b1, k[127:0]});
        do_start(k, 2'd0);
        wait_valid(n, dropped);
        total++;
        if (n !== 34) begin
            bad++;
            $display("FAIL mask_latency got %0d want 34", n);
        end
        for (int i = 0; i < 33; i++) begin
            total++;
            if (kv[i] !== exp_k[i]) begin
                bad++;
                $display("FAIL mask_k%0d got %h want %h", i, kv[i], exp_k[i]);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [255:0] a, b;
        int           n;
        a = rand_key();
        b = rand_key();
        model_keys(a);
        do_start(a, 2'd2);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            start = 1'b0;
            if (n == 11) begin
                start    = 1'b1;
                user_key = b;
                key_len  = 2'd2;
            end
            if (keys_valid) break;
        end
        total++;
        if (n !== 34 || !keys_valid) begin
            bad++;
            $display("FAIL busy_start_latency got %0d want 34", n);
        end
        for (int i = 0; i < 33; i++) begin
            total++;
            if (kv[i] !== exp_k[i]) begin
                bad++;
                $display("FAIL busy_start_k%0d got %h want %h", i, kv[i], exp_k[i]);
            end
        end
    endtask

    task automatic test_restart();
        logic [255:0] k;
        int           n;
        logic         dropped;
        k = rand_key();
        model_keys({63'd0, 1'b1, k[191:0]});
        do_start(k, 2'd1);
        wait_valid(n, dropped);
        total++;
        if (dropped !== 1'b1) begin
            bad++;
            $display("FAIL restart_drop got dropped=%b want 1", dropped);
        end
        total++;
        if (n !== 34) begin
            bad++;
            $display("FAIL restart_latency got %0d want 34", n);
        end
        for (int i = 0; i < 33; i++) begin
            total++;
            if (kv[i] !== exp_k[i]) begin
                bad++;
                $display("FAIL restart_k%0d got %h want %h", i, kv[i], exp_k[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [255:0] k;
        int           n;
        logic         dropped;
        do_start(rand_key(), 2'd2);
        repeat (21) @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_busy_before got %b want 1", busy);
        end
        // rst together with start: rst must win.
        rst      = 1'b1;
        start    = 1'b1;
        user_key = rand_key();
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || keys_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_flags busy=%b valid=%b want 0 0", busy, keys_valid);
        end
        for (int i = 0; i < 33; i++) begin
            total++;
            if (kv[i] !== 128'd0) begin
                bad++;
                $display("FAIL midrst_k%0d got %h want 0", i, kv[i]);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        k = rand_key();
        model_keys(k);
        do_start(k, 2'd3);
        wait_valid(n, dropped);
        total++;
        if (n !== 34) begin
            bad++;
            $display("FAIL midrst_after_latency got %0d want 34", n);
        end
        for (int i = 0; i < 33; i++) begin
            total++;
            if (kv[i] !== exp_k[i]) begin
                bad++;
                $display("FAIL midrst_after_k%0d got %h want %h", i, kv[i], exp_k[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero256();
        test_padding();
        test_masking();
        test_busy_start();
        test_restart();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
